conv_mac_pipe: RTL and testbench

- Parametrised, pipelined signed multiply-accumulate unit for CNN convolution kernels.
- Generalises the single-cycle signed 16x8 multiplier with:
  - configurable operand widths;
  - configurable multiply pipeline depth with clock enable;
  - a per-frame accumulator delimited by a last flag.
- Sits between the window/weight fetch logic and the bias/activation stage. Emits one dot-product result per frame.

---
 rtl/conv_mac_pkg.sv | 43 ++++
 rtl/conv_mac_pipe_mul.sv | 73 +++++++
 rtl/conv_mac_pipe.sv | 150 +++++++++++++++
 tb/tb_conv_mac_pipe.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_mac_pkg.sv
// conv_mac_pkg: shared widths, pipeline depth limit and signed result
// resize helper used by the MAC and the downstream bias stage.
package conv_mac_pkg;

    localparam int DIN0_W    = 16;
    localparam int DIN1_W    = 8;
    localparam int ACC_W     = 32;
    localparam int DOUT_W    = 24;
    localparam int MAX_STAGE = 6;
    localparam int RS_W      = 64;

    typedef struct packed {
        logic            sat;
        logic [RS_W-1:0] val;
    } rs_t;

    // Caller keeps the low ow bits of val; with sat_en the value is
    // clamped into the signed ow-bit range first.
    function automatic rs_t sat_resize(
        input logic signed [RS_W-1:0] v,
        input int                     ow,
        input logic                   sat_en
    );
        logic signed [RS_W-1:0] hi;
        logic signed [RS_W-1:0] lo;
        rs_t                    r;
        hi    = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo    = -hi - 64'sd1;
        r.sat = 1'b0;
        r.val = v;
        if (sat_en) begin
            if (v > hi) begin
                r.val = hi;
                r.sat = 1'b1;
            end else if (v < lo) begin
                r.val = lo;
                r.sat = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/conv_mac_pipe_mul.sv
// conv_mac_pipe_mul: NUM_STAGE-deep pipelined signed multiplier with
// clock enable, carrying valid/last sideband alongside the product.
module conv_mac_pipe_mul
    import conv_mac_pkg::*;
#(
    parameter int NUM_STAGE = 2,
    parameter int A_W       = DIN0_W,
    parameter int B_W       = DIN1_W,
    parameter int PW        = A_W + B_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ce,
    input  logic signed [A_W-1:0] a,
    input  logic signed [B_W-1:0] b,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic signed [PW-1:0] p,
    output logic                 p_valid,
    output logic                 p_last,
    output logic                 pend
);

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] p_q [NUM_STAGE];
    logic signed [PW-1:0] p_d [NUM_STAGE];
    logic [NUM_STAGE-1:0] v_q;
    logic [NUM_STAGE-1:0] v_d;
    logic [NUM_STAGE-1:0] l_q;
    logic [NUM_STAGE-1:0] l_d;

    assign prod = PW'(a) * PW'(b);

    always_comb begin
        p_d[0] = prod;
        v_d[0] = in_valid;
        l_d[0] = in_valid & in_last;
        for (int i = 1; i < NUM_STAGE; i++) begin
            p_d[i] = p_q[i-1];
            v_d[i] = v_q[i-1];
            l_d[i] = l_q[i-1];
        end
    end

    // Beats still behind the output stage belong to a newer frame.
    always_comb begin
        pend = 1'b0;
        for (int i = 0; i < NUM_STAGE - 1; i++) begin
            pend = pend | v_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q <= '0;
            l_q <= '0;
            for (int i = 0; i < NUM_STAGE; i++) begin
                p_q[i] <= '0;
            end
        end else if (ce) begin
            v_q <= v_d;
            l_q <= l_d;
            for (int i = 0; i < NUM_STAGE; i++) begin
                p_q[i] <= p_d[i];
            end
        end
    end

    assign p       = p_q[NUM_STAGE-1];
    assign p_valid = v_q[NUM_STAGE-1];
    assign p_last  = l_q[NUM_STAGE-1];

endmodule

// File: rtl/conv_mac_pipe.sv
// conv_mac_pipe: pipelined signed MAC, one dot product per last-delimited
// frame. Define CONV_MAC_PIPE_SAT_EN for saturating resize and sat_flag.
module conv_mac_pipe
    import conv_mac_pkg::*;
#(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 2,
    parameter int DIN0_WIDTH = DIN0_W,
    parameter int DIN1_WIDTH = DIN1_W,
    parameter int ACC_WIDTH  = ACC_W,
    parameter int DOUT_WIDTH = DOUT_W
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic                         ce,
    input  logic signed [DIN0_WIDTH-1:0] din0,
    input  logic signed [DIN1_WIDTH-1:0] din1,
    input  logic                         in_valid,
    input  logic                         in_last,
    output logic signed [DOUT_WIDTH-1:0] dout,
    output logic                         dout_valid,
    output logic                         busy
`ifdef CONV_MAC_PIPE_SAT_EN
    ,
    output logic                         sat_flag
`endif
);

    localparam int PW = DIN0_WIDTH + DIN1_WIDTH;

    if (ID < 0 || NUM_STAGE < 1 || NUM_STAGE > MAX_STAGE ||
        ACC_WIDTH < PW || DOUT_WIDTH > ACC_WIDTH ||
        ACC_WIDTH > RS_W) begin : g_bad_cfg
        $error("conv_mac_pipe: illegal parameters");
    end

    logic signed [PW-1:0]         m_p;
    logic                         m_v;
    logic                         m_l;
    logic                         m_pend;
    logic                         retire;
    logic signed [ACC_WIDTH-1:0]  acc_nx;
    logic signed [ACC_WIDTH-1:0]  acc_q;
    logic signed [ACC_WIDTH-1:0]  acc_d;
    logic                         first_q;
    logic                         first_d;
    logic signed [DOUT_WIDTH-1:0] dout_q;
    logic signed [DOUT_WIDTH-1:0] dout_d;
    logic                         dv_q;
    logic                         dv_d;
    logic                         busy_q;
    logic                         busy_d;
    rs_t                          rs;
    logic                         unused_rs;

    conv_mac_pipe_mul #(
        .NUM_STAGE (NUM_STAGE),
        .A_W       (DIN0_WIDTH),
        .B_W       (DIN1_WIDTH),
        .PW        (PW)
    ) u_mul (
        .clk      (ap_clk),
        .rst_n    (ap_rst_n),
        .ce       (ce),
        .a        (din0),
        .b        (din1),
        .in_valid (in_valid),
        .in_last  (in_last),
        .p        (m_p),
        .p_valid  (m_v),
        .p_last   (m_l),
        .pend     (m_pend)
    );

    assign retire    = ce & m_v;
    assign acc_nx    = first_q ? ACC_WIDTH'(m_p) : acc_q + ACC_WIDTH'(m_p);
    assign unused_rs = ^rs;

`ifdef CONV_MAC_PIPE_SAT_EN
    assign rs = sat_resize(RS_W'(acc_nx), DOUT_WIDTH, 1'b1);
`else
    assign rs = sat_resize(RS_W'(acc_nx), DOUT_WIDTH, 1'b0);
`endif

    always_comb begin
        acc_d   = acc_q;
        first_d = first_q;
        dout_d  = dout_q;
        dv_d    = dv_q;
        busy_d  = busy_q;
        if (ce) begin
            dv_d   = 1'b0;
            busy_d = in_valid | (busy_q & ~(m_v & m_l & ~m_pend));
        end
        if (retire) begin
            if (m_l) begin
                dout_d  = rs.val[DOUT_WIDTH-1:0];
                dv_d    = 1'b1;
                first_d = 1'b1;
                acc_d   = '0;
            end else begin
                acc_d   = acc_nx;
                first_d = 1'b0;
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            acc_q   <= '0;
            first_q <= 1'b1;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            first_q <= first_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            busy_q  <= busy_d;
        end
    end

`ifdef CONV_MAC_PIPE_SAT_EN
    logic sat_q;
    logic sat_d;

    always_comb begin
        sat_d = sat_q;
        if (retire && m_l) begin
            sat_d = rs.sat;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign sat_flag = sat_q;
`endif

    assign dout       = dout_q;
    assign dout_valid = dv_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_conv_mac_pipe.sv
// tb_conv_mac_pipe: directed vectors with hand-computed frame results
// for conv_mac_pipe at NUM_STAGE=2 and default widths.
module tb_conv_mac_pipe;

    logic               ap_clk   = 1'b0;
    logic               ap_rst_n = 1'b0;
    logic               ce       = 1'b0;
    logic signed [15:0] din0     = '0;
    logic signed [7:0]  din1     = '0;
    logic               in_valid = 1'b0;
    logic               in_last  = 1'b0;
    logic signed [23:0] dout;
    logic               dout_valid;
    logic               busy;
`ifdef CONV_MAC_PIPE_SAT_EN
    logic               sat_flag;
`endif

    int     n_chk  = 0;
    int     n_err  = 0;
    int     cyc    = 0;
    int     t_last = 0;
    int     tl     = 0;
    longint rq[$];
    int     cq[$];
    longint sq[$];

    conv_mac_pipe #(
        .ID         (1),
        .NUM_STAGE  (2),
        .DIN0_WIDTH (16),
        .DIN1_WIDTH (8),
        .ACC_WIDTH  (32),
        .DOUT_WIDTH (24)
    ) dut (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
        .ce         (ce),
        .din0       (din0),
        .din1       (din1),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy)
`ifdef CONV_MAC_PIPE_SAT_EN
        ,
        .sat_flag   (sat_flag)
`endif
    );

    always #5 ap_clk = ~ap_clk;

    always @(posedge ap_clk) cyc <= cyc + 1;

    always @(negedge ap_clk) begin
        if (dout_valid && ce) begin
            rq.push_back(longint'(dout));
            cq.push_back(cyc);
`ifdef CONV_MAC_PIPE_SAT_EN
            sq.push_back(longint'(sat_flag));
`else
            sq.push_back(0);
`endif
        end
    end

    task automatic check(input string tag, input longint got,
                         input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic beat(input logic signed [15:0] a,
                        input logic signed [7:0] b, input logic l);
        din0     = a;
        din1     = b;
        in_valid = 1'b1;
        in_last  = l;
        t_last   = cyc;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic drain(input int n, input string tag);
        int b;
        b = 0;
        while (rq.size() < n && b < 40) begin
            step();
            b++;
        end
        repeat (4) step();
        check({tag, "_count"}, longint'(rq.size()), longint'(n));
    endtask

    function automatic longint res(input int i);
        return (rq.size() > i) ? rq[i] : -64'sd999999999;
    endfunction

    function automatic longint rcyc(input int i);
        return (cq.size() > i) ? longint'(cq[i]) : -64'sd1;
    endfunction

    function automatic longint rsat(input int i);
        return (sq.size() > i) ? sq[i] : -64'sd1;
    endfunction

    task automatic clear();
        rq.delete();
        cq.delete();
        sq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        ce = 1'b1;
        repeat (3) step();
        check("rst_dout", longint'(dout), 0);
        check("rst_dv", longint'(dout_valid), 0);
        check("rst_busy", longint'(busy), 0);
        ap_rst_n = 1'b1;
        step();

        beat(100, 3, 1'b0);
        check("t1_busy_open", longint'(busy), 1);
        beat(-200, 5, 1'b0);
        beat(7, -128, 1'b1);
        tl = t_last;
        drain(1, "t1");
        check("t1_dout", res(0), -1596);
        check("t1_latency", rcyc(0) - longint'(tl), 3);
        check("t1_sat", rsat(0), 0);
        check("t1_busy_end", longint'(busy), 0);
        clear();

        beat(-32768, -128, 1'b1);
        tl = t_last;
        beat(1, 1, 1'b0);
        beat(2, 2, 1'b1);
        check("t2_busy_overlap", longint'(busy), 1);
        drain(2, "t2");
        check("t2_single", res(0), 4194304);
        check("t2_lat", rcyc(0) - longint'(tl), 3);
        check("t2_next", res(1), 5);
        check("t2_gap", rcyc(1) - rcyc(0), 2);
        clear();

        beat(6, 6, 1'b1);
        beat(1, 1, 1'b0);
        idle(1);
        check("t2b_busy_pend", longint'(busy), 1);
        beat(1, 1, 1'b1);
        drain(2, "t2b");
        check("t2b_a", res(0), 36);
        check("t2b_b", res(1), 2);
        check("t2b_busy_end", longint'(busy), 0);
        clear();

        beat(32767, 127, 1'b0);
        beat(32767, 127, 1'b0);
        beat(32767, 127, 1'b1);
        drain(1, "t3");
`ifdef CONV_MAC_PIPE_SAT_EN
        check("t3_dout", res(0), 8388607);
        check("t3_sat", rsat(0), 1);
`else
        check("t3_dout", res(0), -4292989);
`endif
        clear();

        beat(10, 10, 1'b0);
        beat(10, 10, 1'b1);
        tl = t_last;
        ce = 1'b0;
        idle(4);
        ce = 1'b1;
        drain(1, "t4");
        check("t4_dout", res(0), 200);
        check("t4_latency", rcyc(0) - longint'(tl), 7);
        clear();

        beat(10, 10, 1'b1);
        step();
        step();
        check("t4h_dv", longint'(dout_valid), 1);
        check("t4h_dout", longint'(dout), 100);
        ce = 1'b0;
        step();
        step();
        check("t4h_dv_hold", longint'(dout_valid), 1);
        check("t4h_dout_hold", longint'(dout), 100);
        ce = 1'b1;
        step();
        check("t4h_dv_drop", longint'(dout_valid), 0);
        drain(1, "t4h");
        check("t4h_res", res(0), 100);
        clear();

        beat(9, 9, 1'b0);
        beat(9, 9, 1'b0);
        ap_rst_n = 1'b0;
        step();
        check("t5_rst_busy", longint'(busy), 0);
        ap_rst_n = 1'b1;
        beat(5, 5, 1'b1);
        drain(1, "t5");
        check("t5_dout", res(0), 25);
        clear();

        beat(3, 3, 1'b0);
        idle(3);
        in_last = 1'b1;
        step();
        in_last = 1'b0;
        beat(4, 4, 1'b1);
        drain(1, "t6");
        check("t6_dout", res(0), 25);
        clear();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
